layer_backward: RTL

Backward-pass counterpart of the forward layer. Given the error vector at a layer's outputs, it computes the error vector at that layer's inputs, input_error[j] = Σ_i W[i][j]·output_error[i]. It uses one time-multiplexed multiply-accumulate unit and reads weights through an external synchronous port. It sits between adjacent forward layers in the training path, with one instance per layer and LAYER_INDEX matching the forward layer.

---
 rtl/layer_pkg.sv | 34 +++
 rtl/layer_backward_mac.sv | 34 +++
 rtl/layer_backward.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/layer_pkg.sv
// Shared types and arithmetic helpers for the layer datapaths.
package layer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wide enough to sum output_neurons full-width signed products without overflow.
    function automatic int acc_width(input int data_width, input int output_neurons);
        return 2 * data_width + $clog2(output_neurons) + 1;
    endfunction

    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] acc,
        input int                 frac_bits,
        input int                 data_width
    );
        logic signed [63:0] shifted;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        shifted = acc >>> frac_bits;
        max_v   = (64'sd1 <<< (data_width - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (data_width - 1));
        if (shifted > max_v) begin
            return max_v;
        end else if (shifted < min_v) begin
            return min_v;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/layer_backward_mac.sv
// Signed multiply-accumulate: registered accumulator plus the combinational
// next sum, so the owner can capture a finished dot product on its last term.
module mac_unit #(
    parameter int DATAWIDTH = 16,
    parameter int ACC_W     = 35
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear_i,
    input  logic                        enable_i,
    input  logic signed [DATAWIDTH-1:0] a_i,
    input  logic signed [DATAWIDTH-1:0] b_i,
    output logic signed [ACC_W-1:0]     sum_o
);

    logic signed [2*DATAWIDTH-1:0] product;
    logic signed [ACC_W-1:0]       acc_q;

    assign product = a_i * b_i;
    assign sum_o   = acc_q + ACC_W'(product);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (enable_i) begin
            acc_q <= sum_o;
        end
    end

endmodule

// File: rtl/layer_backward.sv
// Backward pass of one layer: input_error[j] = sum_i W[i][j] * output_error[i],
// computed column by column on a single MAC fed by a 1-cycle-latency weight port.
module layer_backward
    import layer_pkg::*;
#(
    parameter int DATAWIDTH      = 16,
    parameter int FRAC_BITS      = 8,
    parameter int INPUT_NEURONS  = 2,
    parameter int OUTPUT_NEURONS = 3,
    parameter int LAYER_INDEX    = 0
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic                                           start,
    input  logic [DATAWIDTH*OUTPUT_NEURONS-1:0]            output_error,
    output logic [$clog2(INPUT_NEURONS*OUTPUT_NEURONS)-1:0] weight_addr,
    output logic                                           weight_en,
    input  logic signed [DATAWIDTH-1:0]                    weight_data,
    output logic                                           busy,
    output logic                                           done,
    output logic [DATAWIDTH*INPUT_NEURONS-1:0]             input_error
);

    localparam int ADDR_W = $clog2(INPUT_NEURONS * OUTPUT_NEURONS);
    localparam int ACC_W  = acc_width(DATAWIDTH, OUTPUT_NEURONS);
    localparam int I_W    = $clog2(OUTPUT_NEURONS + 1);
    localparam int J_W    = (INPUT_NEURONS > 1) ? $clog2(INPUT_NEURONS) : 1;
    localparam logic [I_W-1:0] I_LAST = I_W'(OUTPUT_NEURONS);
    localparam logic [J_W-1:0] J_LAST = J_W'(INPUT_NEURONS - 1);

    if (LAYER_INDEX < 0) begin : g_bad_layer_index
        $error("LAYER_INDEX must be non-negative");
    end

    state_t                                 state_q, state_d;
    logic [I_W-1:0]                         i_q, i_d;
    logic [J_W-1:0]                         j_q, j_d;
    logic [DATAWIDTH*OUTPUT_NEURONS-1:0]    snap_q, snap_d;
    logic [DATAWIDTH*INPUT_NEURONS-1:0]     shadow_q, shadow_d;
    logic [DATAWIDTH*INPUT_NEURONS-1:0]     input_error_q, input_error_d;
    logic                                   done_q, done_d;
    logic [ADDR_W-1:0]                      addr_q;
    logic [ADDR_W-1:0]                      addr_calc;
    logic [I_W-1:0]                         snap_idx;
    logic signed [DATAWIDTH-1:0]            snap_elem;
    logic                                   mac_clear;
    logic                                   mac_en;
    logic signed [ACC_W-1:0]                mac_sum;

    // Inner cycle i issues the address for term i; the data returns one cycle
    // later, so the term being accumulated is always i-1.
    assign addr_calc = ADDR_W'(int'(i_q) * INPUT_NEURONS + int'(j_q));
    assign snap_idx  = (i_q == '0) ? '0 : i_q - I_W'(1);
    assign snap_elem = $signed(snap_q[int'(snap_idx)*DATAWIDTH +: DATAWIDTH]);

    assign weight_addr = weight_en ? addr_calc : addr_q;
    assign busy        = (state_q != IDLE) || done_q;
    assign done        = done_q;
    assign input_error = input_error_q;

    mac_unit #(
        .DATAWIDTH (DATAWIDTH),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (mac_clear),
        .enable_i (mac_en),
        .a_i      (weight_data),
        .b_i      (snap_elem),
        .sum_o    (mac_sum)
    );

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        snap_d        = snap_q;
        shadow_d      = shadow_q;
        input_error_d = input_error_q;
        done_d        = 1'b0;
        mac_clear     = 1'b0;
        mac_en        = 1'b0;
        weight_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    snap_d    = output_error;
                    i_d       = '0;
                    j_d       = '0;
                    mac_clear = 1'b1;
                end
            end
            RUN: begin
                weight_en = (i_q != I_LAST);
                mac_en    = (i_q != '0);
                if (i_q == I_LAST) begin
                    shadow_d[int'(j_q)*DATAWIDTH +: DATAWIDTH] =
                        DATAWIDTH'(sat_shift(64'(mac_sum), FRAC_BITS, DATAWIDTH));
                    mac_clear = 1'b1;
                    i_d       = '0;
                    if (j_q == J_LAST) begin
                        state_d = DONE;
                    end else begin
                        j_d = j_q + J_W'(1);
                    end
                end else begin
                    i_d = i_q + I_W'(1);
                end
            end
            DONE: begin
                state_d       = IDLE;
                input_error_d = shadow_q;
                done_d        = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            i_q           <= '0;
            j_q           <= '0;
            snap_q        <= '0;
            shadow_q      <= '0;
            input_error_q <= '0;
            done_q        <= 1'b0;
            addr_q        <= '0;
        end else begin
            state_q       <= state_d;
            i_q           <= i_d;
            j_q           <= j_d;
            snap_q        <= snap_d;
            shadow_q      <= shadow_d;
            input_error_q <= input_error_d;
            done_q        <= done_d;
            addr_q        <= weight_addr;
        end
    end

endmodule
